// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register, BYPASS/IDCODE
// data registers and control of an external boundary scan register chain.
module tap_controller #(
    parameter int unsigned IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tms,
    input  logic       tdi,
    output logic       tdo,
    output logic       tdo_en,
    input  logic       bsr_tdo,
    output logic       bsr_clk,
    output logic       bsr_shift_dr,
    output logic       bsr_update_dr,
    output logic       bsr_mode,
    output logic [3:0] state
);

    // Standard 1149.1 state encoding, so debug tools can read the state port directly.
    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
        PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
        PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] OP_EXTEST = '0;
    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(2);

    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
    logic [IR_WIDTH-1:0] ir_q;
    logic                bypass_q, bypass_d;
    logic [31:0]         idcode_q, idcode_d;
    logic                bsr_en_q, bsr_en_d;
    logic                sel_idcode, sel_bsr;

    assign sel_idcode = (ir_q == OP_IDCODE);
    assign sel_bsr    = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE);

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = tms ? TLR    : RTI;
            RTI:     state_d = tms ? SEL_DR : RTI;
            SEL_DR:  state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = tms ? EX1_DR : SH_DR;
            SH_DR:   state_d = tms ? EX1_DR : SH_DR;
            EX1_DR:  state_d = tms ? UPD_DR : PAU_DR;
            PAU_DR:  state_d = tms ? EX2_DR : PAU_DR;
            EX2_DR:  state_d = tms ? UPD_DR : SH_DR;
            UPD_DR:  state_d = tms ? SEL_DR : RTI;
            SEL_IR:  state_d = tms ? TLR    : CAP_IR;
            CAP_IR:  state_d = tms ? EX1_IR : SH_IR;
            SH_IR:   state_d = tms ? EX1_IR : SH_IR;
            EX1_IR:  state_d = tms ? UPD_IR : PAU_IR;
            PAU_IR:  state_d = tms ? EX2_IR : PAU_IR;
            EX2_IR:  state_d = tms ? UPD_IR : SH_IR;
            UPD_IR:  state_d = tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    always_comb begin
        ir_shift_d = ir_shift_q;
        bypass_d   = bypass_q;
        idcode_d   = idcode_q;
        tdo        = 1'b0;
        case (state_q)
            CAP_IR: ir_shift_d = OP_IDCODE;
            SH_IR: begin
                ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
                tdo        = ir_shift_q[0];
            end
            CAP_DR: begin
                bypass_d = 1'b0;
                idcode_d = IDCODE_VAL;
            end
            SH_DR: begin
                bypass_d = tdi;
                idcode_d = {tdi, idcode_q[31:1]};
                tdo      = sel_bsr ? bsr_tdo : (sel_idcode ? idcode_q[0] : bypass_q);
            end
            default: ;
        endcase
    end

    assign tdo_en       = (state_q == SH_DR) || (state_q == SH_IR);
    assign bsr_shift_dr = (state_q == SH_DR) && sel_bsr;
    assign bsr_en_d     = sel_bsr && ((state_q == CAP_DR) || (state_q == SH_DR));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TLR;
            ir_shift_q <= OP_IDCODE;
            bypass_q   <= 1'b0;
            idcode_q   <= '0;
        end else begin
            state_q    <= state_d;
            ir_shift_q <= ir_shift_d;
            bypass_q   <= bypass_d;
            idcode_q   <= idcode_d;
        end
    end

    // Active IR and the ClockDR enable change on the falling edge, mid-cycle of the state that drives them.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            ir_q     <= OP_IDCODE;
            bsr_en_q <= 1'b0;
        end else begin
            bsr_en_q <= bsr_en_d;
            if (state_q == TLR) begin
                ir_q <= OP_IDCODE;
            end else if (state_q == UPD_IR) begin
                ir_q <= ir_shift_q;
            end
        end
    end

    // en_q only moves while clk is low, so the AND cannot glitch.
    assign bsr_clk       = clk & bsr_en_q;
    assign bsr_update_dr = ~clk & (state_q == UPD_DR) & sel_bsr;
    assign bsr_mode      = (ir_q == OP_EXTEST);
    assign state         = state_q;

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller with an 8-bit boundary scan chain model
// and a table-driven reference of the 1149.1 state graph.
module tb_tap_controller;

    localparam logic [31:0] IDCODE = 32'h1BA5_E0C3;
    localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SELDR = 4'h7, S_CAPDR = 4'h6,
                           S_SHDR = 4'h2, S_EX1DR = 4'h1, S_PAUDR = 4'h3, S_EX2DR = 4'h0,
                           S_UPDDR = 4'h5, S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR = 4'hA,
                           S_EX1IR = 4'h9, S_PAUIR = 4'hB, S_EX2IR = 4'h8, S_UPDIR = 4'hD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tms = 1'b1;
    logic       tdi = 1'b0;
    logic       tdo, tdo_en, bsr_tdo, bsr_clk, bsr_shift_dr, bsr_update_dr, bsr_mode;
    logic [3:0] state;

    logic [7:0] bsr_sr  = 8'h00;
    logic [7:0] bsr_out = 8'h00;
    logic [7:0] bsr_pin = 8'h00;
    int         n_bclk  = 0;
    int         n_upd   = 0;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_state;
    logic [3:0] on0 [16];
    logic [3:0] on1 [16];

    always #5 clk = ~clk;

    tap_controller #(.IR_WIDTH(4), .IDCODE_VAL(IDCODE)) dut (
        .clk(clk), .rst(rst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
        .bsr_tdo(bsr_tdo), .bsr_clk(bsr_clk), .bsr_shift_dr(bsr_shift_dr),
        .bsr_update_dr(bsr_update_dr), .bsr_mode(bsr_mode), .state(state)
    );

    // Boundary scan chain: capture parallel_in or shift on bsr_clk, latch outputs on update.
    always @(posedge bsr_clk) begin
        n_bclk <= n_bclk + 1;
        if (bsr_shift_dr) bsr_sr <= {tdi, bsr_sr[7:1]};
        else              bsr_sr <= bsr_pin;
    end
    always @(posedge bsr_update_dr) begin
        n_upd   <= n_upd + 1;
        bsr_out <= bsr_sr;
    end
    assign bsr_tdo = bsr_sr[0];

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "timeout");
    end

    task automatic init_graph();
        // {state, next on tms=0, next on tms=1}, straight from the 1149.1 diagram
        logic [11:0] tab [16] = '{
            {S_TLR,   S_RTI,   S_TLR},   {S_RTI,   S_RTI,   S_SELDR},
            {S_SELDR, S_CAPDR, S_SELIR}, {S_CAPDR, S_SHDR,  S_EX1DR},
            {S_SHDR,  S_SHDR,  S_EX1DR}, {S_EX1DR, S_PAUDR, S_UPDDR},
            {S_PAUDR, S_PAUDR, S_EX2DR}, {S_EX2DR, S_SHDR,  S_UPDDR},
            {S_UPDDR, S_RTI,   S_SELDR}, {S_SELIR, S_CAPIR, S_TLR},
            {S_CAPIR, S_SHIR,  S_EX1IR}, {S_SHIR,  S_SHIR,  S_EX1IR},
            {S_EX1IR, S_PAUIR, S_UPDIR}, {S_PAUIR, S_PAUIR, S_EX2IR},
            {S_EX2IR, S_SHIR,  S_UPDIR}, {S_UPDIR, S_RTI,   S_SELDR}};
        for (int i = 0; i < 16; i++) begin
            on0[tab[i][11:8]] = tab[i][7:4];
            on1[tab[i][11:8]] = tab[i][3:0];
        end
    endtask

    task automatic tick(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge clk);
        #1;
        exp_state = t ? on1[exp_state] : on0[exp_state];
    endtask

    task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
        dout = '0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            tick(i == n - 1, din[i]);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic scan_ir(input logic [3:0] op, output logic [3:0] cap);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cap[i] = tdo;
            tick(i == 3, op[i]);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        rst = 1'b1;
        tms = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        obs = {state == S_TLR, tdo, tdo_en, bsr_shift_dr, bsr_update_dr, bsr_mode, bsr_clk};
        n_checks++;
        if (obs !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_outputs: {tlr,tdo,tdo_en,shift,update,mode,bclk} got %b expected 1000000", obs);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bsr_update_dr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_update_low_phase: got %b expected 0", bsr_update_dr);
        end
        rst = 1'b0;
        exp_state = S_TLR;
        repeat (5) tick(1'b1, 1'b0);
        n_checks++;
        if (state !== S_TLR) begin
            n_fail++;
            $display("FAIL five_tms_tlr: got %h expected %h", state, S_TLR);
        end
        tick(1'b0, 1'b0);
        n_checks++;
        if (state !== S_RTI || bsr_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL reach_rti: state %h mode %b expected %h mode 0", state, bsr_mode, S_RTI);
        end
    endtask

    task automatic test_idcode();
        logic [31:0] dout;
        scan_dr(32, $urandom, dout);
        n_checks++;
        if (dout !== IDCODE) begin
            n_fail++;
            $display("FAIL idcode_scan: got %h expected %h", dout, IDCODE);
        end
        n_checks++;
        if (dout[0] !== 1'b1 || state !== S_RTI) begin
            n_fail++;
            $display("FAIL idcode_lsb_rti: bit0 %b state %h expected 1 and %h", dout[0], state, S_RTI);
        end
    endtask

    task automatic test_bypass();
        logic [3:0]  cap;
        logic [3:0]  op;
        logic [31:0] din, dout;
        scan_ir(4'b1111, cap);
        n_checks++;
        if (cap !== 4'b0001) begin
            n_fail++;
            $display("FAIL ir_capture: got %b expected 0001", cap);
        end
        scan_dr(4, 32'b1101, dout);
        n_checks++;
        if (dout[3:0] !== 4'b1010) begin
            n_fail++;
            $display("FAIL bypass_1011: tdo bits got %b expected 1010", dout[3:0]);
        end
        // Undefined opcodes must behave exactly like BYPASS.
        for (int k = 0; k < 3; k++) begin
            op  = 4'($urandom_range(3, 14));
            scan_ir(op, cap);
            din = $urandom & 32'hFFFF;
            scan_dr(16, din, dout);
            n_checks++;
            if (dout !== ((din << 1) & 32'hFFFF) || bsr_mode !== 1'b0) begin
                n_fail++;
                $display("FAIL bypass_op_%h: got %h mode %b expected %h mode 0", op, dout, bsr_mode, (din << 1) & 32'hFFFF);
            end
        end
    endtask

    task automatic test_sample();
        logic [3:0] cap;
        logic [7:0] din, obs;
        int         b0, u0, bad;
        bsr_pin = 8'hA5;
        scan_ir(4'b0010, cap);
        din = 8'($urandom);
        if (din == 8'h3C) din = 8'hC3;
        b0  = n_bclk;
        u0  = n_upd;
        bad = 0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            obs[i] = tdo;
            if (bsr_shift_dr !== 1'b1 || tdo_en !== 1'b1) bad++;
            tick(i == 7, din[i]);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sample_shift_ctrl: %0d ShDR cycles without shift_dr/tdo_en", bad);
        end
        n_checks++;
        if (obs !== 8'hA5) begin
            n_fail++;
            $display("FAIL sample_capture: tdo got %h expected a5", obs);
        end
        n_checks++;
        if (n_bclk - b0 != 9 || bsr_sr !== din) begin
            n_fail++;
            $display("FAIL sample_bsr_clk: pulses %0d chain %h expected 9 and %h", n_bclk - b0, bsr_sr, din);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        n_checks++;
        if (n_upd - u0 != 1 || bsr_out !== din || bsr_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL sample_update: pulses %0d out %h mode %b expected 1 %h 0", n_upd - u0, bsr_out, bsr_mode, din);
        end
    endtask

    task automatic test_extest();
        logic [3:0] cap;
        int         b1, u0;
        scan_ir(4'b0000, cap);
        n_checks++;
        if (bsr_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL extest_mode: got %b expected 1", bsr_mode);
        end
        u0 = n_upd;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) tick(i == 7, 8'h3C >> i);
        b1 = n_bclk;
        repeat (3) tick(1'b0, 1'($urandom));
        n_checks++;
        if (state !== S_PAUDR || n_bclk != b1 || bsr_sr !== 8'h3C) begin
            n_fail++;
            $display("FAIL extest_pause: state %h pulses %0d chain %h expected %h 0 3c", state, n_bclk - b1, bsr_sr, S_PAUDR);
        end
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        @(negedge clk);
        #1;
        n_checks++;
        if (bsr_update_dr !== 1'b1) begin
            n_fail++;
            $display("FAIL extest_update_mid: got %b expected 1", bsr_update_dr);
        end
        tick(1'b0, 1'b0);
        n_checks++;
        if (n_upd - u0 != 1 || bsr_out !== 8'h3C || bsr_mode !== 1'b1 || bsr_update_dr !== 1'b0) begin
            n_fail++;
            $display("FAIL extest_update: pulses %0d out %h mode %b upd %b expected 1 3c 1 0", n_upd - u0, bsr_out, bsr_mode, bsr_update_dr);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [31:0] dout;
        int          u0;
        u0 = n_upd;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'($urandom));
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (state !== S_TLR || bsr_mode !== 1'b0 || tdo_en !== 1'b0 || bsr_shift_dr !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_scan: state %h mode %b tdo_en %b shift %b expected %h 0 0 0", state, bsr_mode, tdo_en, bsr_shift_dr, S_TLR);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        exp_state = S_TLR;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        n_checks++;
        if (n_upd != u0 || state !== S_RTI) begin
            n_fail++;
            $display("FAIL rst_no_update: pulses %0d state %h expected 0 %h", n_upd - u0, state, S_RTI);
        end
        scan_dr(32, $urandom, dout);
        n_checks++;
        if (dout !== IDCODE || bsr_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ir_idcode: got %h mode %b expected %h 0", dout, bsr_mode, IDCODE);
        end
    endtask

    task automatic test_state_walk();
        int          tour [20] = '{0,1,0,0,1,0,1,1,1,1,0,0,1,0,1,1,1,1,1,1};
        logic [15:0] visited;
        logic [3:0]  cap;
        logic [31:0] dout;
        repeat (5) tick(1'b1, 1'b0);
        visited = '0;
        visited[state] = 1'b1;
        for (int i = 0; i < 320; i++) begin
            if (i < 20) tick(tour[i][0], 1'($urandom));
            else if (i % 50 == 0) begin
                repeat (5) tick(1'b1, 1'b0);
                n_checks++;
                if (state !== S_TLR) begin
                    n_fail++;
                    $display("FAIL walk_five_ones_%0d: got %h expected %h", i, state, S_TLR);
                end
            end else tick(1'($urandom), 1'($urandom));
            visited[state] = 1'b1;
            n_checks++;
            if (state !== exp_state || tdo_en !== (exp_state == S_SHDR || exp_state == S_SHIR)) begin
                n_fail++;
                $display("FAIL walk_step_%0d: state %h tdo_en %b expected %h", i, state, tdo_en, exp_state);
            end
        end
        n_checks++;
        if (visited !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL walk_coverage: visited %h expected ffff", visited);
        end
        repeat (5) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        scan_ir(4'b1111, cap);
        repeat (5) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        scan_dr(32, $urandom, dout);
        n_checks++;
        if (dout !== IDCODE) begin
            n_fail++;
            $display("FAIL tms_tlr_ir_idcode: got %h expected %h", dout, IDCODE);
        end
    endtask

    initial begin
        init_graph();
        test_reset();
        test_idcode();
        test_bypass();
        test_sample();
        test_extest();
        test_reset_mid_scan();
        test_state_walk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
